// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage fed by the ALU control decoder's one-hot enables.
// Stage 1 registers the operands and enables. Stage 2 computes add, sub, and or or
// from the stage 1 contents and registers the result and its flags.
// Handshake is valid/ready on both sides.
// The input side is ready whenever stage 1 can move. This gives one operation per cycle when unstalled.
module alu_exec_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ADD_EN,
  input  logic             SUB_EN,
  input  logic             AND_EN,
  input  logic             OR_EN,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  // Enable bundle order: {ADD, SUB, AND, OR}
  localparam logic [3:0] EN_ADD = 4'b1000;
  localparam logic [3:0] EN_SUB = 4'b0100;
  localparam logic [3:0] EN_AND = 4'b0010;
  localparam logic [3:0] EN_OR  = 4'b0001;

  // Stage 1 state
  logic             s1_v_q, s1_v_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_en_q, s1_en_d;

  // Stage 2 state (drives the outputs directly)
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  // Execute results computed from stage 1 contents
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero, alu_carry, alu_ovf, alu_ill;

  logic s2_adv, s1_adv;

  // Advance conditions; in_ready depends only on state, out_ready and rst, never on in_valid
  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = s1_adv && !rst;
  end

  // Stage 1 next state: capture operands and enables only on an input transfer
  always_comb begin
    s1_v_d  = s1_v_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    s1_en_d = s1_en_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_a_d  = op_a;
        s1_b_d  = op_b;
        s1_en_d = {ADD_EN, SUB_EN, AND_EN, OR_EN};
      end
    end
  end

  // Execute the selected operation; any non-one-hot enable set is flagged illegal with zeroed data
  always_comb begin
    sum_ext   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff_ext  = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (s1_en_q)
      EN_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      EN_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        // Top bit of the extended difference is the unsigned borrow (a < b)
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != s1_a_q[WIDTH-1]);
      end
      EN_AND: alu_res = s1_a_q & s1_b_q;
      EN_OR:  alu_res = s1_a_q | s1_b_q;
      default: alu_ill = 1'b1;
    endcase
    alu_zero = !alu_ill && (alu_res == '0);
  end

  // Stage 2 next state: load when the consumer side can move, otherwise hold every output bit
  always_comb begin
    s2_v_d  = s2_v_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        res_d   = alu_res;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        ovf_d   = alu_ovf;
        ill_d   = alu_ill;
      end
    end
  end

  // Pipeline registers; reset clears valids and the visible result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_en_q <= '0;
      s2_v_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      s1_v_q  <= s1_v_d;
      s1_a_q  <= s1_a_d;
      s1_b_q  <= s1_b_d;
      s1_en_q <= s1_en_d;
      s2_v_q  <= s2_v_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = s2_v_q;
  assign result    = res_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit.
// It runs table-driven directed vectors and hand-written sequences for back-to-back traffic, backpressure and reset.
// It then runs randomized traffic.
// A negedge scoreboard checks every output transfer against an arithmetic reference model.
module tb_alu_exec_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       ADD_EN, SUB_EN, AND_EN, OR_EN;
  logic [7:0] op_a, op_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       zero, carry, overflow, illegal;

  logic [11:0] outvec;
  assign outvec = {result, zero, carry, overflow, illegal};

  int n_tests = 0;
  int n_fail  = 0;
  bit sb_on   = 1'b0;

  alu_exec_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ADD_EN(ADD_EN), .SUB_EN(SUB_EN), .AND_EN(AND_EN), .OR_EN(OR_EN),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow),
    .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic rules. It returns {result, zero, carry, overflow, illegal}.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] en);
    int ia = int'(a);
    int ib = int'(b);
    int sa = (ia >= 128) ? ia - 256 : ia;
    int sb = (ib >= 128) ? ib - 256 : ib;
    int r  = 0;
    int s  = 0;
    logic c = 1'b0;
    logic o = 1'b0;
    if ($countones(en) != 1) return {8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    if (en[3]) begin
      r = (ia + ib) % 256;
      c = (ia + ib) > 255;
      s = sa + sb;
      o = (s > 127) || (s < -128);
    end else if (en[2]) begin
      r = (ia - ib + 256) % 256;
      c = ia < ib;
      s = sa - sb;
      o = (s > 127) || (s < -128);
    end else if (en[1]) begin
      r = ia & ib;
    end else begin
      r = ia | ib;
    end
    return {r[7:0], (r == 0), c, o, 1'b0};
  endfunction

  // Scoreboard: queue expected results on input transfers and compare them on output transfers.
  // It also checks that the outputs hold stable while stalled.
  logic [11:0] exp_q[$];
  logic [12:0] prev_out;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (sb_on) begin
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) chk("stall_hold", {out_valid, outvec}, prev_out);
        if (in_valid && in_ready)
          exp_q.push_back(model(op_a, op_b, {ADD_EN, SUB_EN, AND_EN, OR_EN}));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got result %h with nothing outstanding", outvec);
          end else begin
            chk("sb_data", outvec, exp_q.pop_front());
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, outvec};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] en,
                       input logic v);
    op_a     = a;
    op_b     = b;
    ADD_EN   = en[3];
    SUB_EN   = en[2];
    AND_EN   = en[1];
    OR_EN    = en[0];
    in_valid = v;
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  en;
    logic [11:0] exp;
  } vec_t;

  // A single op on an idle pipeline with out_ready=1.
  // If the transfer happens in cycle c, out_valid is expected in cycle c+2.
  task automatic do_op(input vec_t v, input int idx);
    int lat;
    out_ready = 1'b1;
    drive(v.a, v.b, v.en, 1'b1);
    #1;
    chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      step();
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), lat, 2);
    $display("[TB] vec%0d a=%h b=%h en=%b -> res=%h z=%b c=%b o=%b ill=%b", idx, v.a, v.b,
             v.en, result, zero, carry, overflow, illegal);
    chk($sformatf("vec%0d_out", idx), outvec, v.exp);
    step();
  endtask

  vec_t vecs[10];
  vec_t bp[3];
  logic [11:0] bp_exp[3];

  initial begin
    int accepts;
    int idx;
    int ngot;
    bit acc_now;

    rst = 1'b1;
    out_ready = 1'b0;
    drive(8'h00, 8'h00, 4'b0000, 1'b0);
    sb_on = 1'b1;

    // {result, zero, carry, overflow, illegal}
    vecs[0] = '{8'hFF, 8'h01, 4'b1000, {8'h00, 4'b1100}};
    vecs[1] = '{8'h80, 8'h01, 4'b0100, {8'h7F, 4'b0010}};
    vecs[2] = '{8'h00, 8'h01, 4'b0100, {8'hFF, 4'b0100}};
    vecs[3] = '{8'hA5, 8'h0F, 4'b0010, {8'h05, 4'b0000}};
    vecs[4] = '{8'hA0, 8'h0F, 4'b0001, {8'hAF, 4'b0000}};
    vecs[5] = '{8'h7F, 8'h01, 4'b1000, {8'h80, 4'b0010}};
    vecs[6] = '{8'h05, 8'h05, 4'b0100, {8'h00, 4'b1000}};
    vecs[7] = '{8'h03, 8'h01, 4'b1100, {8'h00, 4'b0001}};
    vecs[8] = '{8'h5A, 8'h3C, 4'b0000, {8'h00, 4'b0001}};
    vecs[9] = '{8'h3C, 8'hC3, 4'b0010, {8'h00, 4'b1000}};

    bp[0] = '{8'h10, 8'h01, 4'b1000, 12'h0};
    bp[1] = '{8'h20, 8'h02, 4'b1000, 12'h0};
    bp[2] = '{8'h30, 8'h03, 4'b1000, 12'h0};
    bp_exp[0] = {8'h11, 4'b0000};
    bp_exp[1] = {8'h22, 4'b0000};
    bp_exp[2] = {8'h33, 4'b0000};

    // Reset state
    step();
    chk("reset_outputs", {out_valid, outvec}, 13'h0);
    chk("reset_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready_high", in_ready, 1);

    // Directed table
    for (int i = 0; i < 10; i++) do_op(vecs[i], i);

    // Back-to-back sequence: AND, OR, ADD, SUB on consecutive cycles
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive(vecs[k+3].a, vecs[k+3].b, vecs[k+3].en, 1'b1);
      else in_valid = 1'b0;
      #1;
      if (k < 4) chk($sformatf("b2b_in_ready%0d", k), in_ready, 1);
      if (k >= 2) begin
        $display("[TB] b2b cycle%0d out_valid=%b res=%h", k, out_valid, result);
        chk($sformatf("b2b_out%0d", k - 2), {out_valid, outvec}, {1'b1, vecs[k+1].exp});
      end
      step();
    end
    step();

    // Backpressure: offer 3 ADDs while the consumer is stalled
    out_ready = 1'b0;
    idx = 0;
    accepts = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 3) drive(bp[idx].a, bp[idx].b, bp[idx].en, 1'b1);
      else in_valid = 1'b0;
      #1;
      acc_now = in_valid && in_ready;
      if (c >= 2) chk($sformatf("bp_hold%0d", c), {out_valid, outvec}, {1'b1, bp_exp[0]});
      step();
      if (acc_now) begin
        idx++;
        accepts++;
      end
    end
    #1;
    chk("bp_accepts", accepts, 2);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1;
    ngot = 0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 3) drive(bp[idx].a, bp[idx].b, bp[idx].en, 1'b1);
      else in_valid = 1'b0;
      #1;
      acc_now = in_valid && in_ready;
      if (out_valid) begin
        $display("[TB] bp release out%0d res=%h", ngot, result);
        if (ngot < 3) begin
          chk($sformatf("bp_order%0d", ngot), outvec, bp_exp[ngot]);
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL bp_duplicate: got extra result %h expected none", result);
        end
        ngot++;
      end
      step();
      if (acc_now) idx++;
    end
    chk("bp_count", ngot, 3);

    // Reset with two transactions in flight
    out_ready = 1'b0;
    drive(8'h11, 8'h22, 4'b1000, 1'b1);
    step();
    drive(8'h44, 8'h0F, 4'b0010, 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready_low", in_ready, 0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {out_valid, outvec}, 13'h0);
    chk("rst_mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rst_no_stale%0d", c), out_valid, 0);
    end

    // Randomized traffic checked by the scoreboard
    for (int c = 0; c < 600; c++) begin
      logic [3:0] en;
      logic [7:0] a, b;
      if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
      else en = 4'b0001 << $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? ((|$urandom_range(0, 1)) ? 8'h80 : 8'h7F)
                                      : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? ((|$urandom_range(0, 1)) ? 8'hFF : 8'h01)
                                      : 8'($urandom);
      drive(a, b, en, ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
